// File: rtl/sample_address_sequencer_pkg.sv
// ============================================================================
// sound_board_pkg
// Shared sound-board constants and the playback sequencer state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sound_board_pkg;

  localparam int SB_ADDR_W    = 15;
  localparam int SB_CLK_HZ    = 50_000_000;
  localparam int SB_SAMPLE_HZ = 8_000;
  localparam int SB_CLK_DIV   = SB_CLK_HZ / SB_SAMPLE_HZ;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_PLAY = 1'b1
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/sample_address_sequencer_if.sv
// ============================================================================
// sample_address_sequencer_if
// Pad control inputs and playback address outputs of one sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sample_address_sequencer_if #(
  parameter int ADDR_W = 15
);
  logic              trigger;
  logic              stop;
  logic [ADDR_W-1:0] address;
  logic              en;
  logic              busy;
  logic              done;

  // master drives the pad controls, slave is the sequencer itself
  modport master (output trigger, output stop,
                  input  address, input en, input busy, input done);
  modport slave  (input  trigger, input  stop,
                  output address, output en, output busy, output done);
endinterface

`default_nettype wire

// File: rtl/sample_address_sequencer_tick_gen.sv
// ============================================================================
// sample_tick_gen
// Sample-rate divider: tick high on the last cycle of every CLK_DIV period.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_tick_gen #(
  parameter int unsigned CLK_DIV = 6250,
  parameter int          DIV_W   = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] C_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = (count_q == C_LAST);

  always_comb begin
    count_d = count_q + DIV_W'(1);
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sample_address_sequencer.sv
// ============================================================================
// sample_address_sequencer
// Per-pad playback address generator; SAMPLE_SEQ_LOOP_EN enables looping
// while the trigger is held at the end of a clip.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sample_address_sequencer
  import sound_board_pkg::*;
#(
  parameter int          ADDR_W     = SB_ADDR_W,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned END_ADDR   = 32767,
  parameter int unsigned CLK_DIV    = SB_CLK_DIV,
  parameter int          DIV_W      = 13
) (
  input  logic                        clock,
  input  logic                        reset,
  sample_address_sequencer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] C_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] C_END   = ADDR_W'(END_ADDR);

  if ((END_ADDR < START_ADDR) || (CLK_DIV < 1) ||
      (longint'(END_ADDR) >= (longint'(1) << ADDR_W)) ||
      (longint'(CLK_DIV) - 1 >= (longint'(1) << DIV_W))) begin : g_param_check
    $fatal(1, "sample_address_sequencer: illegal parameter set");
  end

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              trig_q, trig_d;
  logic              trig_rise;
  logic              tick;
  logic              clear;
  logic              loop_ok;

  assign trig_rise = bus.trigger & ~trig_q;

`ifdef SAMPLE_SEQ_LOOP_EN
  assign loop_ok = bus.trigger;
`else
  assign loop_ok = 1'b0;
`endif

  sample_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // priority: stop > trig_rise > tick
  always_comb begin
    state_d   = state_q;
    address_d = address_q;
    done_d    = 1'b0;
    trig_d    = bus.trigger;
    clear     = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        address_d = C_START;
        clear     = 1'b1;
        if (trig_rise && !bus.stop) begin
          state_d = SEQ_PLAY;
        end
      end
      SEQ_PLAY: begin
        if (bus.stop) begin
          state_d   = SEQ_IDLE;
          address_d = C_START;
          clear     = 1'b1;
        end else if (trig_rise) begin
          address_d = C_START;
          clear     = 1'b1;
        end else if (tick) begin
          if (address_q != C_END) begin
            address_d = address_q + ADDR_W'(1);
          end else if (loop_ok) begin
            address_d = C_START;
          end else begin
            state_d   = SEQ_IDLE;
            address_d = C_START;
            done_d    = 1'b1;
            clear     = 1'b1;
          end
        end
      end
      default: begin
        state_d   = SEQ_IDLE;
        address_d = C_START;
        clear     = 1'b1;
      end
    endcase
    en_d = (state_d == SEQ_PLAY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= SEQ_IDLE;
      address_q <= C_START;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      trig_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      address_q <= address_d;
      en_q      <= en_d;
      done_q    <= done_d;
      trig_q    <= trig_d;
    end
  end

  assign bus.address = address_q;
  assign bus.en      = en_q;
  assign bus.busy    = en_q;
  assign bus.done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_address_sequencer.sv
// ============================================================================
// tb_sample_address_sequencer
// Two sequencers (CLK_DIV=4 and CLK_DIV=1) against a cycle-count playback model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sample_address_sequencer;

  localparam int START = 16;
  localparam int LAST  = 19;
  localparam int NADDR = LAST - START + 1;
`ifdef SAMPLE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trigger = 1'b0;
  logic stop = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  sample_address_sequencer_if #(.ADDR_W(15)) bus0 ();
  sample_address_sequencer_if #(.ADDR_W(15)) bus1 ();

  assign bus0.trigger = trigger;
  assign bus0.stop    = stop;
  assign bus1.trigger = trigger;
  assign bus1.stop    = stop;

  sample_address_sequencer #(
    .ADDR_W(15), .START_ADDR(START), .END_ADDR(LAST), .CLK_DIV(4), .DIV_W(2)
  ) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));

  sample_address_sequencer #(
    .ADDR_W(15), .START_ADDR(START), .END_ADDR(LAST), .CLK_DIV(1), .DIV_W(1)
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a clip is a count of elapsed playback cycles; address = START + elapsed/div.
  bit m_play [2];
  int m_el   [2];
  bit m_done [2];
  bit m_trig_prev = 1'b1;
  int m_div  [2] = '{4, 1};

  initial begin
    m_play = '{0, 0};
    m_el   = '{0, 0};
    m_done = '{0, 0};
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          m_play[k] = 0; m_el[k] = 0; m_done[k] = 0;
        end
        m_trig_prev = 1'b1;
      end else begin
        bit rise;
        rise = trigger && !m_trig_prev;
        for (int k = 0; k < 2; k++) begin
          m_done[k] = 0;
          if (m_play[k]) begin
            if (stop) m_play[k] = 0;
            else if (rise) m_el[k] = 0;
            else begin
              m_el[k]++;
              if (m_el[k] == NADDR * m_div[k]) begin
                if (LOOP && trigger) m_el[k] = 0;
                else begin
                  m_play[k] = 0; m_el[k] = 0; m_done[k] = 1;
                end
              end
            end
          end else if (rise && !stop) begin
            m_play[k] = 1; m_el[k] = 0;
          end
        end
        m_trig_prev = trigger;
      end
    end
  end

  function automatic int exp_addr(input int k);
    return m_play[k] ? START + m_el[k] / m_div[k] : START;
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rst addr0", int'(bus0.address), START);
        check("rst en0",   int'(bus0.en),   0);
        check("rst done0", int'(bus0.done), 0);
        check("rst addr1", int'(bus1.address), START);
        check("rst en1",   int'(bus1.en),   0);
      end else begin
        check("addr0", int'(bus0.address), exp_addr(0));
        check("en0",   int'(bus0.en),   int'(m_play[0]));
        check("busy0", int'(bus0.busy), int'(m_play[0]));
        check("done0", int'(bus0.done), int'(m_done[0]));
        check("addr1", int'(bus1.address), exp_addr(1));
        check("en1",   int'(bus1.en),   int'(m_play[1]));
        check("busy1", int'(bus1.busy), int'(m_play[1]));
        check("done1", int'(bus1.done), int'(m_done[1]));
      end
    end
  end

  task automatic wait_addr0(input int a);
    for (int i = 0; i < 200; i++) begin
      if (bus0.en && int'(bus0.address) == a) break;
      @(negedge clock);
    end
    check("wait_addr0", int'(bus0.address), a);
  endtask

  task automatic pulse_trigger();
    @(negedge clock); trigger = 1'b1;
    @(negedge clock); trigger = 1'b0;
  endtask

  int en0_cnt, en1_cnt, done0_cnt, done1_cnt;
  int a4, a12, d16;

  initial begin
    repeat (3) @(negedge clock);
    check("pin reset addr", int'(bus0.address), 16);
    check("pin reset en",   int'(bus0.en), 0);
    reset = 1'b0;

    // single-cycle trigger pulse: 16 cycles of 0x10..0x13, then done
    @(negedge clock); trigger = 1'b1;
    en0_cnt = 0; en1_cnt = 0; done0_cnt = 0; done1_cnt = 0; a4 = 0; a12 = 0; d16 = 0;
    for (int j = 0; j < 22; j++) begin
      @(negedge clock);
      trigger = 1'b0;
      en0_cnt += int'(bus0.en); en1_cnt += int'(bus1.en);
      done0_cnt += int'(bus0.done); done1_cnt += int'(bus1.done);
      if (j == 4)  a4 = int'(bus0.address);
      if (j == 12) a12 = int'(bus0.address);
      if (j == 16) d16 = int'(bus0.done);
    end
    check("pin en cycles div4", en0_cnt, 16);
    check("pin done count div4", done0_cnt, 1);
    check("pin en cycles div1", en1_cnt, 4);
    check("pin done count div1", done1_cnt, 1);
    check("pin addr j4", a4, 17);
    check("pin addr j12", a12, 19);
    check("pin done j16", d16, 1);

    // trigger held through reset release must not start playback
    @(negedge clock); reset = 1'b1; trigger = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    en0_cnt = 0;
    for (int j = 0; j < 50; j++) begin
      @(negedge clock); en0_cnt += int'(bus0.en);
    end
    check("held trigger en cycles", en0_cnt, 0);
    trigger = 1'b0;
    pulse_trigger();
    check("later edge starts en", int'(bus0.en), 1);
    check("later edge addr", int'(bus0.address), 16);

    // retrigger at 0x12
    wait_addr0(18);
    trigger = 1'b1;
    @(negedge clock);
    trigger = 1'b0;
    check("retrigger addr", int'(bus0.address), 16);
    check("retrigger en", int'(bus0.en), 1);
    en0_cnt = 0; done0_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      en0_cnt += int'(bus0.en); done0_cnt += int'(bus0.done);
      @(negedge clock);
    end
    check("retrigger en cycles", en0_cnt, 16);
    check("retrigger done count", done0_cnt, 1);

    // stop together with a trigger edge at 0x11
    pulse_trigger();
    wait_addr0(17);
    trigger = 1'b1; stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop en", int'(bus0.en), 0);
    check("stop addr", int'(bus0.address), 16);
    check("stop done", int'(bus0.done), 0);
    repeat (5) @(negedge clock);
    check("stop stays idle", int'(bus0.en), 0);
    trigger = 1'b0;

    // asynchronous reset between clock edges
    pulse_trigger();
    wait_addr0(18);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async rst en", int'(bus0.en), 0);
    check("async rst addr", int'(bus0.address), 16);
    check("async rst done", int'(bus0.done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // trigger held across the end of the clip
    @(negedge clock); trigger = 1'b1;
    en0_cnt = 0; done0_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      en0_cnt += int'(bus0.en); done0_cnt += int'(bus0.done);
    end
`ifdef SAMPLE_SEQ_LOOP_EN
    check("loop held en cycles", en0_cnt, 40);
    check("loop held done count", done0_cnt, 0);
    trigger = 1'b0;
    done0_cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clock); done0_cnt += int'(bus0.done);
    end
    check("loop release done count", done0_cnt, 1);
    check("loop release en", int'(bus0.en), 0);
`else
    check("held en cycles", en0_cnt, 16);
    check("held done count", done0_cnt, 1);
    trigger = 1'b0;
`endif

    // randomized trigger/stop traffic against the model
    for (int j = 0; j < 3000; j++) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) trigger = ~trigger;
      stop = ($urandom_range(0, 19) == 0);
    end
    stop = 1'b0; trigger = 1'b0;
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
